// File: rtl/fifo_serial_tx.sv
// rtl/fifo_serial_tx.sv - pops FIFO words and sends each as a start/data(LSB first)/stop serial frame; parity via FIFO_SERIAL_TX_PARITY_EN
module fifo_serial_tx #(
   parameter int M            = 16,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [M-1:0] din,
   input  logic         empty,
   output logic         read,
   output logic         tx,
   output logic         busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(M) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [M-1:0]    r_shift;
   logic [M-1:0]    w_shift_next;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_next;
   logic [IW-1:0]   r_idx;
   logic [IW-1:0]   w_idx_next;
   logic            r_tx;
   logic            r_busy;
   logic            w_tx_next;
   logic            w_busy_next;
   logic            w_read;
   logic            w_cnt_done;
   logic            w_par;

   assign w_cnt_done = (r_cnt == CNT_LAST);
   assign read       = w_read;
   assign tx         = r_tx;
   assign busy       = r_busy;

`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic r_par;
   // Even parity of the popped word, captured at pop time since the shift register is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_par <= 1'b0;
      end else if (w_read) begin
         r_par <= ^din;
      end
   end
   assign w_par = r_par;
`else
   assign w_par = 1'b0;
`endif

   // Frame sequencing: next state, shift/counter updates, pop strobe and next line level.
   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_read       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!empty && rst) begin
               w_read       = 1'b1;
               w_shift_next = din;
               w_cnt_next   = '0;
               w_idx_next   = '0;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_cnt_done) begin
               w_cnt_next   = '0;
               w_idx_next   = '0;
               w_state_next = S_DATA;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (w_cnt_done) begin
               w_cnt_next   = '0;
               w_shift_next = r_shift >> 1;
               if (r_idx == IDX_LAST) begin
                  w_idx_next = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end else begin
                  w_idx_next = r_idx + 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
`ifdef FIFO_SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (w_cnt_done) begin
               w_cnt_next   = '0;
               w_state_next = S_STOP;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_cnt_done) begin
               w_cnt_next   = '0;
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
         end
      endcase
   end

   // Line level and busy are derived from the upcoming state so the registered outputs line up with it.
   always_comb begin
      w_tx_next   = 1'b1;
      w_busy_next = (w_state_next != S_IDLE);
      case (w_state_next)
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = w_par;
         default:  w_tx_next = 1'b1;
      endcase
   end

   // State, datapath and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_tx    <= w_tx_next;
         r_busy  <= w_busy_next;
      end
   end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// tb/tb_fifo_serial_tx.sv - self-checking bench for fifo_serial_tx against a frame-level model
module tb_fifo_serial_tx;

   localparam int M = 16;
   localparam int C = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int PB      = 1;
   localparam int LIT_LEN = 76;
   localparam int LIT_PER = 77;
`else
   localparam int PB      = 0;
   localparam int LIT_LEN = 72;
   localparam int LIT_PER = 73;
`endif
   localparam int F = (M + 2 + PB) * C;

   typedef bit bq_t[$];

   logic         clk;
   logic         rst;
   logic [M-1:0] din;
   logic         empty;
   logic         read;
   logic         tx;
   logic         busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   bit          expq[$];
   bit          cur[$];
   int          len_q[$];
   int          read_q[$];
   logic [M-1:0] dec_q[$];
   bit          par_q[$];

   fifo_serial_tx #(.M(M), .CLKS_PER_BIT(C)) dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .empty (empty),
      .read  (read),
      .tx    (tx),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Serial frame of a word: start, data LSB first, optional even parity, stop; each bit C cycles.
   task automatic mk_frame(input logic [M-1:0] w, output bq_t f);
      bit bits[$];
      f = {};
      bits.push_back(1'b0);
      for (int i = 0; i < M; i++) bits.push_back(w[i]);
      if (PB == 1) bits.push_back(^w);
      bits.push_back(1'b1);
      foreach (bits[b]) for (int k = 0; k < C; k++) f.push_back(bits[b]);
   endtask

   task automatic clear_logs();
      len_q = {};
      read_q = {};
      dec_q = {};
      par_q = {};
   endtask

   // Model and compare: every cycle, sampled on the falling edge.
   always @(negedge clk) begin
      bit   e_tx, e_busy, e_read;
      bq_t  f;
      logic [M-1:0] w;
      cyc++;
      if (!rst) begin
         expq.delete();
         e_tx = 1'b1;
         e_busy = 1'b0;
      end else if (expq.size() > 0) begin
         e_tx = expq.pop_front();
         e_busy = 1'b1;
      end else begin
         e_tx = 1'b1;
         e_busy = 1'b0;
      end
      e_read = rst && !e_busy && !empty;
      check("tx", tx, e_tx);
      check("busy", busy, e_busy);
      check("read", read, e_read);
      if (e_read) begin
         mk_frame(din, f);
         foreach (f[i]) expq.push_back(f[i]);
      end
      if (read) read_q.push_back(cyc);
      if (busy) begin
         cur.push_back(tx);
      end else if (cur.size() > 0) begin
         len_q.push_back(cur.size());
         if (cur.size() == F) begin
            w = '0;
            for (int i = 0; i < M; i++) w[i] = cur[C * (1 + i) + C / 2];
            dec_q.push_back(w);
            if (PB == 1) par_q.push_back(cur[C * (1 + M) + C / 2]);
         end
         cur.delete();
      end
   end

   task automatic wait_read();
      bit seen = 1'b0;
      for (int i = 0; i < 4 * F && !seen; i++) begin
         @(negedge clk);
         if (read) seen = 1'b1;
      end
      check("read_timeout", seen, 1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single_word(input logic [M-1:0] w);
      clear_logs();
      din = w;
      empty = 1'b0;
      wait_read();
      step();
      empty = 1'b1;
      din = '0;
      repeat (F + 4) @(negedge clk);
   endtask

   initial begin
      bq_t f;
      bit lit[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
      logic [M-1:0] b2b[3] = '{16'h0001, 16'hFFFF, 16'h8000};
      int bad;

      rst = 1'b0;
      empty = 1'b0;
      din = 16'hA5C3;

      // reset holds outputs quiet even with a word available
      repeat (5) begin
         @(negedge clk);
         check("rst_tx", tx, 1);
         check("rst_busy", busy, 0);
         check("rst_read", read, 0);
      end

      // pin the model's frame against hand-derived bits
      mk_frame(16'hA5C3, f);
      check("model_len", f.size(), LIT_LEN);
      check("model_start", f[0], 0);
      check("model_stop", f[f.size() - 1], 1);
      bad = 0;
      for (int i = 0; i < 16; i++) if (f[C * (1 + i)] != lit[i]) bad++;
      check("model_bits", bad, 0);

      // single word, read in the same cycle reset releases
      clear_logs();
      step();
      rst = 1'b1;
      wait_read();
      step();
      empty = 1'b1;
      repeat (F + 4) @(negedge clk);
      check("single_reads", read_q.size(), 1);
      check("single_busy_len", len_q.size() > 0 ? len_q[0] : 0, LIT_LEN);
      check("single_word", dec_q.size() > 0 ? dec_q[0] : 32'hDEAD, 16'hA5C3);

      // back-to-back drain of three words
      clear_logs();
      step();
      for (int k = 0; k < 3; k++) begin
         din = b2b[k];
         empty = 1'b0;
         wait_read();
         step();
      end
      empty = 1'b1;
      repeat (F + 4) @(negedge clk);
      check("b2b_reads", read_q.size(), 3);
      check("b2b_per0", read_q.size() > 2 ? read_q[1] - read_q[0] : 0, LIT_PER);
      check("b2b_per1", read_q.size() > 2 ? read_q[2] - read_q[1] : 0, LIT_PER);
      check("b2b_w0", dec_q.size() > 2 ? dec_q[0] : 32'hDEAD, 16'h0001);
      check("b2b_w1", dec_q.size() > 2 ? dec_q[1] : 32'hDEAD, 16'hFFFF);
      check("b2b_w2", dec_q.size() > 2 ? dec_q[2] : 32'hDEAD, 16'h8000);

      // input isolation during a frame
      clear_logs();
      step();
      din = 16'h1234;
      empty = 1'b0;
      wait_read();
      for (int k = 1; k <= F; k++) begin
         step();
         din = 16'($urandom);
         empty = k[0];
      end
      step();
      empty = 1'b1;
      repeat (4) @(negedge clk);
      check("iso_reads", read_q.size(), 1);
      check("iso_word", dec_q.size() > 0 ? dec_q[0] : 32'hDEAD, 16'h1234);

      // reset during data bit 5, then a fresh frame
      step();
      din = 16'h5A5A;
      empty = 1'b0;
      wait_read();
      step();
      empty = 1'b1;
      repeat (C * 6 + 1) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", busy, 0);
      check("midrst_read", read, 0);
      step();
      step();
      clear_logs();
      din = 16'h00FF;
      empty = 1'b0;
      rst = 1'b1;
      wait_read();
      step();
      empty = 1'b1;
      repeat (F + 4) @(negedge clk);
      check("midrst_len", len_q.size() > 0 ? len_q[0] : 0, LIT_LEN);
      check("midrst_word", dec_q.size() > 0 ? dec_q[0] : 32'hDEAD, 16'h00FF);

`ifdef FIFO_SERIAL_TX_PARITY_EN
      single_word(16'h0001);
      check("par_0001", par_q.size() > 0 ? par_q[0] : 2, 1);
      check("par_len", len_q.size() > 0 ? len_q[0] : 0, 76);
      single_word(16'h0003);
      check("par_0003", par_q.size() > 0 ? par_q[0] : 2, 0);
`else
      single_word(16'h0001);
      check("w_0001", dec_q.size() > 0 ? dec_q[0] : 32'hDEAD, 16'h0001);
`endif

      // randomized traffic with occasional reset pulses
      for (int k = 0; k < 3000; k++) begin
         step();
         din = 16'($urandom);
         empty = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 400) != 0);
      end
      step();
      rst = 1'b1;
      empty = 1'b1;
      repeat (F + 4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
